// File: rtl/spi_seq_pkg.sv
// Shared state encoding and sizing helpers for the SPI transfer sequencer.
// SPI_SEQ_GAP_EN adds the inter-byte GAP state to the encoding.
package spi_seq_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 8;

  // Occupancy counter width: one extra bit so DEPTH itself is representable
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(FIFO_DEPTH_DEF);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_CAPTURE   = 3'd4
`ifdef SPI_SEQ_GAP_EN
    , S_GAP     = 3'd5
`endif
  } seq_state_e;

endpackage

// File: rtl/spi_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO; DEPTH must be a power of two.
// Pointers wrap naturally; a push is ignored when full, a pop when empty.
module spi_byte_fifo
  import spi_seq_pkg::*;
#(
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  DEPTH  = FIFO_DEPTH_DEF,
  localparam int CNT_W  = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign push_ok_s = push && (count_r != CNT_W'(DEPTH));
  assign pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
  assign rd_data   = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Feeds spi_master one byte at a time from a TX FIFO and collects replies into an RX FIFO.
// Define SPI_SEQ_GAP_EN to insert GAP_CYCLES idle cycles after each capture.
module spi_xfer_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int BUSY_TO    = 4
`ifdef SPI_SEQ_GAP_EN
  , parameter int GAP_CYCLES = 2
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              spi_start,
  output logic [DATA_W-1:0] spi_data_in,
  input  logic              spi_busy,
  input  logic [DATA_W-1:0] spi_data_out,
  output logic              seq_busy,
  output logic              err_to,
  input  logic              err_clr
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);
  localparam int TO_W  = $clog2(BUSY_TO) + 1;
`ifdef SPI_SEQ_GAP_EN
  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
`endif

  seq_state_e        state_r;
  logic [TO_W-1:0]   to_cnt_r;
`ifdef SPI_SEQ_GAP_EN
  logic [GAP_W-1:0]  gap_cnt_r;
`endif
  logic              spi_start_r;
  logic [DATA_W-1:0] spi_data_in_r;
  logic              err_to_r;

  logic [CNT_W-1:0]  tx_count_s;
  logic [CNT_W-1:0]  rx_count_s;
  logic [DATA_W-1:0] tx_head_s;
  logic              tx_nonempty_s;
  logic              rx_room_s;
  logic              launch_s;
  logic              rx_push_s;
  logic              to_fire_s;

  spi_byte_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (tx_valid),
    .wr_data (tx_data),
    .pop     (launch_s),
    .rd_data (tx_head_s),
    .count   (tx_count_s)
  );

  spi_byte_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (rx_push_s),
    .wr_data (spi_data_out),
    .pop     (rx_ready),
    .rd_data (rx_data),
    .count   (rx_count_s)
  );

  // Only one byte is ever in flight and it has landed by the time we are back
  // in IDLE, so the RX count alone bounds the room for the next reply.
  assign tx_nonempty_s = (tx_count_s != {CNT_W{1'b0}});
  assign rx_room_s     = (rx_count_s < CNT_W'(FIFO_DEPTH));
  assign launch_s      = (state_r == S_IDLE) && tx_nonempty_s && rx_room_s;
  assign rx_push_s     = (state_r == S_CAPTURE);
  // Busy is sampled on the BUSY_TO-1 cycles following the start pulse
  assign to_fire_s     = (state_r == S_WAIT_BUSY) && !spi_busy &&
                         (to_cnt_r == TO_W'(BUSY_TO - 2));

  assign tx_ready    = (tx_count_s != CNT_W'(FIFO_DEPTH));
  assign rx_valid    = (rx_count_s != {CNT_W{1'b0}});
  assign spi_start   = spi_start_r;
  assign spi_data_in = spi_data_in_r;
  assign err_to      = err_to_r;
  assign seq_busy    = (state_r != S_IDLE) || tx_nonempty_s;

  // Transfer sequencing FSM with registered start/data/error outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      to_cnt_r      <= {TO_W{1'b0}};
`ifdef SPI_SEQ_GAP_EN
      gap_cnt_r     <= {GAP_W{1'b0}};
`endif
      spi_start_r   <= 1'b0;
      spi_data_in_r <= {DATA_W{1'b0}};
      err_to_r      <= 1'b0;
    end else begin
      spi_start_r <= 1'b0;
      if (to_fire_s) begin
        err_to_r <= 1'b1;
      end else if (err_clr) begin
        err_to_r <= 1'b0;
      end else begin
        err_to_r <= err_to_r;
      end

      case (state_r)
        S_IDLE: begin
          if (launch_s) begin
            state_r       <= S_LAUNCH;
            spi_start_r   <= 1'b1;
            spi_data_in_r <= tx_head_s;
          end
        end
        S_LAUNCH: begin
          state_r  <= S_WAIT_BUSY;
          to_cnt_r <= {TO_W{1'b0}};
        end
        S_WAIT_BUSY: begin
          if (spi_busy) begin
            state_r <= S_WAIT_DONE;
          end else if (to_fire_s) begin
            state_r <= S_IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!spi_busy) begin
            state_r <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
`ifdef SPI_SEQ_GAP_EN
          state_r   <= S_GAP;
          gap_cnt_r <= {GAP_W{1'b0}};
`else
          state_r   <= S_IDLE;
`endif
        end
`ifdef SPI_SEQ_GAP_EN
        S_GAP: begin
          if (gap_cnt_r == GAP_W'(GAP_CYCLES - 1)) begin
            state_r <= S_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end
        end
`endif
        default: state_r <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Self-checking bench for spi_xfer_sequencer with a behavioural spi_master model.
// Honours SPI_SEQ_GAP_EN when defined.
module tb_spi_xfer_sequencer;

  localparam int DW  = 8;
  localparam int BTO = 4;
`ifdef SPI_SEQ_GAP_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          spi_start;
  logic [DW-1:0] spi_data_in;
  logic          spi_busy;
  logic [DW-1:0] spi_data_out;
  logic          seq_busy;
  logic          err_to;
  logic          err_clr;

  always #5 clk = ~clk;

  spi_xfer_sequencer #(
    .DATA_W(DW), .FIFO_DEPTH(8), .BUSY_TO(BTO)
`ifdef SPI_SEQ_GAP_EN
    , .GAP_CYCLES(GAP)
`endif
  ) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .spi_start(spi_start), .spi_data_in(spi_data_in), .spi_busy(spi_busy),
    .spi_data_out(spi_data_out), .seq_busy(seq_busy), .err_to(err_to), .err_clr(err_clr)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // spi_master model: busy rises model_dly cycles after start for model_len cycles, echoes data^FF
  logic model_en = 1'b1;
  int   model_dly = 2;
  int   model_len = 16;
  int   m_ctr = 0;
  bit   m_act = 1'b0;

  logic [DW-1:0] start_q[$];
  int            start_cyc_q[$];
  logic [DW-1:0] rx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      m_act    <= 1'b0;
      spi_busy <= 1'b0;
      spi_data_out <= 8'h00;
    end else if (spi_start && model_en) begin
      m_act        <= 1'b1;
      m_ctr        <= 1;
      spi_busy     <= 1'b0;
      spi_data_out <= spi_data_in ^ 8'hFF;
    end else if (m_act) begin
      m_ctr    <= m_ctr + 1;
      spi_busy <= (m_ctr >= model_dly) && (m_ctr < model_dly + model_len);
      if (m_ctr >= model_dly + model_len) m_act <= 1'b0;
    end else begin
      spi_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst && spi_start) begin
      start_q.push_back(spi_data_in);
      start_cyc_q.push_back(cyc);
    end
    if (!rst && rx_valid && rx_ready) rx_q.push_back(rx_data);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [DW-1:0] b);
    int n = 0;
    while (!tx_ready && n < 300) begin
      step();
      n++;
    end
    chk("push_ready", {31'd0, tx_ready}, 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  task automatic wait_rxq(input int cnt, input int limit);
    int n = 0;
    while (rx_q.size() < cnt && n < limit) begin
      step();
      n++;
    end
    chk("rx_count", rx_q.size(), cnt);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!spi_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", {31'd0, spi_start}, 32'd1);
  endtask

  typedef struct {
    logic [DW-1:0] tx;
    int            dly;
    int            len;
    logic [DW-1:0] exp_rx;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{8'hAA, 2, 16, 8'h55};
    vecs[1] = '{8'h00, 1, 1,  8'hFF};
    vecs[2] = '{8'h3C, 3, 4,  8'hC3};
    vecs[3] = '{8'hFF, 2, 2,  8'h00};

    rst = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
    repeat (3) step();
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_start", {31'd0, spi_start}, 32'd0);
    chk("rst_data_in", {24'd0, spi_data_in}, 32'd0);
    chk("rst_err_to", {31'd0, err_to}, 32'd0);
    chk("rst_seq_busy", {31'd0, seq_busy}, 32'd0);
    rst = 1'b0;
    step();

    // Single-byte transfers from the table
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      model_dly = vecs[i].dly;
      model_len = vecs[i].len;
      start_q.delete();
      push_byte(vecs[i].tx);
      while (!rx_valid && n < 100) begin
        step();
        n++;
      end
      chk("v_rx_valid", {31'd0, rx_valid}, 32'd1);
      chk("v_starts", start_q.size(), 1);
      if (start_q.size() > 0) chk("v_start_data", {24'd0, start_q[0]}, {24'd0, vecs[i].tx});
      chk("v_rx_data", {24'd0, rx_data}, {24'd0, vecs[i].exp_rx});
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
      chk("v_rx_popped", {31'd0, rx_valid}, 32'd0);
      repeat (GAP + 2) step();
      chk("v_idle", {31'd0, seq_busy}, 32'd0);
    end

    // Burst: long busy keeps byte 1 in flight while 8 more fill the TX FIFO
    model_dly = 1; model_len = 40;
    start_q.delete(); start_cyc_q.delete(); rx_q.delete();
    rx_ready = 1'b1;
    for (int i = 1; i <= 9; i++) push_byte(8'(i));
    chk("burst_full", {31'd0, tx_ready}, 32'd0);
    wait_rxq(9, 1000);
    for (int i = 0; i < 9; i++) begin
      logic [DW-1:0] e;
      e = 8'(i + 1);
      if (i < start_q.size()) chk("burst_start", {24'd0, start_q[i]}, {24'd0, e});
      if (i < rx_q.size()) chk("burst_rx", {24'd0, rx_q[i]}, {24'd0, e ^ 8'hFF});
      if (i > 0 && i < start_cyc_q.size())
        chk("burst_spacing", start_cyc_q[i] - start_cyc_q[i-1], model_len + 4 + GAP);
    end

    // RX backpressure: captures stop once the RX FIFO holds 8
    model_dly = 1; model_len = 2;
    rx_ready = 1'b0;
    start_q.delete(); rx_q.delete();
    for (int i = 0; i < 10; i++) push_byte(8'(8'h10 + i));
    repeat (150) step();
    chk("bp_starts", start_q.size(), 8);
    chk("bp_rx_valid", {31'd0, rx_valid}, 32'd1);
    chk("bp_seq_busy", {31'd0, seq_busy}, 32'd1);
    rx_ready = 1'b1;
    wait_rxq(10, 400);
    for (int i = 0; i < 10; i++) begin
      logic [DW-1:0] e;
      e = 8'(8'h10 + i) ^ 8'hFF;
      if (i < rx_q.size()) chk("bp_rx", {24'd0, rx_q[i]}, {24'd0, e});
    end
    chk("bp_starts_all", start_q.size(), 10);

    // Timeout: busy never rises
    model_en = 1'b0;
    rx_q.delete();
    push_byte(8'hA5);
    wait_start();
    repeat (BTO - 1) @(negedge clk);
    chk("to_before", {31'd0, err_to}, 32'd0);
    @(negedge clk);
    chk("to_set", {31'd0, err_to}, 32'd1);
    repeat (10) step();
    chk("to_no_rx", rx_q.size(), 0);
    model_en = 1'b1;
    push_byte(8'h5A);
    wait_rxq(1, 100);
    if (rx_q.size() > 0) chk("to_next_rx", {24'd0, rx_q[0]}, 32'h000000A5);
    chk("to_sticky", {31'd0, err_to}, 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_cleared", {31'd0, err_to}, 32'd0);

    // Timeout while err_clr held: set wins, clear takes effect next cycle
    repeat (GAP + 2) step();
    model_en = 1'b0;
    err_clr = 1'b1;
    push_byte(8'h77);
    wait_start();
    repeat (BTO) @(negedge clk);
    chk("to_set_wins", {31'd0, err_to}, 32'd1);
    @(negedge clk);
    chk("to_clr_after", {31'd0, err_to}, 32'd0);
    err_clr = 1'b0;
    model_en = 1'b1;
    repeat (4) step();

    // Reset mid-transfer with 3 bytes queued
    model_dly = 1; model_len = 30;
    rx_ready = 1'b0;
    start_q.delete(); rx_q.delete();
    for (int i = 0; i < 4; i++) push_byte(8'(8'h21 + i));
    repeat (3) step();
    chk("mid_busy", {31'd0, spi_busy}, 32'd1);
    rst = 1'b1;
    step();
    chk("mid_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("mid_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("mid_start", {31'd0, spi_start}, 32'd0);
    chk("mid_seq_busy", {31'd0, seq_busy}, 32'd0);
    rst = 1'b0;
    repeat (40) step();
    chk("mid_no_restart", start_q.size(), 1);
    chk("mid_rx_empty", {31'd0, rx_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_xfer_sequencer.md
Name: spi_xfer_sequencer

Overview:
Upstream feeder for spi_master. Buffers outgoing bytes in a TX FIFO and issues one single-cycle start pulse with data_in per byte. Waits for busy to complete, then captures data_out into an RX FIFO. Gives host logic valid/ready byte streams instead of the raw start/busy protocol.

Parameters:
DATA_W, 8, width of SPI byte; must match spi_master data_in/data_out.
FIFO_DEPTH, 8, entries in each of TX and RX FIFO; power of two, >=2.
BUSY_TO, 4, clk cycles allowed after start pulse for spi_busy to rise before timeout error.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
tx_data  in  DATA_W  byte to transmit.
tx_valid  in  1  tx_data valid.
tx_ready  out  1  TX FIFO not full.
rx_data  out  DATA_W  received byte, head of RX FIFO.
rx_valid  out  1  RX FIFO not empty.
rx_ready  in  1  consumer accepts rx_data.
spi_start  out  1  one-cycle start pulse to spi_master.
spi_data_in  out  DATA_W  byte to spi_master, held stable from the start pulse until capture.
spi_busy  in  1  spi_master busy.
spi_data_out  in  DATA_W  spi_master received byte, valid once busy falls.
seq_busy  out  1  high when not IDLE or TX FIFO not empty.
err_to  out  1  sticky timeout flag.
err_clr  in  1  clears err_to.

Behaviour:
- Reset (sync, rst=1 at clk edge): both FIFOs emptied, FSM->IDLE. spi_start=0, spi_data_in=0, err_to=0, rx_valid=0, tx_ready=1, seq_busy=0. A reset mid-transfer abandons the byte; spi_master is reset by its own domain logic.
- TX push when tx_valid&&tx_ready. RX pop when rx_valid&&rx_ready. Both FIFOs are first-word-fall-through; pointers wrap modulo FIFO_DEPTH. Full/empty are tracked with a count of width clog2(FIFO_DEPTH)+1. A simultaneous push and pop when full or empty is legal; count is unchanged except push-on-empty or pop-on-full, which follow the normal rules (push blocked when full; pop blocked when empty).
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, CAPTURE.
- IDLE: moves to LAUNCH only when TX FIFO not empty AND RX FIFO count+pending < FIFO_DEPTH. No received byte is ever dropped.
- LAUNCH (1 cycle): pops TX head into spi_data_in register. spi_start=1 this cycle only. -> WAIT_BUSY.
- WAIT_BUSY: spi_busy=1 -> WAIT_DONE. If BUSY_TO cycles pass without busy: set err_to, discard the byte (no RX push), -> IDLE.
- WAIT_DONE: stay while spi_busy=1. On spi_busy=0 -> CAPTURE.
- CAPTURE (1 cycle): push spi_data_out into RX FIFO. -> IDLE.
- Back-to-back throughput: minimum 3 idle clk between consecutive start pulses (CAPTURE, IDLE, LAUNCH).
- err_clr and a new timeout in the same cycle: set wins.
- tx_ready and rx_valid are derived from registered counts, with no combinational path from tx_valid or rx_ready.

Optional Feature:
SPI_SEQ_GAP_EN. When defined, adds a GAP state after CAPTURE holding for GAP_CYCLES (extra parameter, default 2). This guarantees cs_n deassert time between bytes. When undefined, there is no GAP state and GAP_CYCLES is absent. CAPTURE goes straight to IDLE.

Decomposition:
- Package spi_seq_pkg: FSM state encoding enum, DATA_W default, localparam for the counter width clog2(FIFO_DEPTH)+1.
- One natural sub-module: spi_byte_fifo (sync FWFT FIFO, params DATA_W/DEPTH), instantiated twice, for TX and RX.

Test Plan:
- Single byte: push 0xAA, model busy high 2 clk after start for 16 clk, data_out=0x55 -> exactly one spi_start pulse with spi_data_in=0xAA; rx_data=0x55, rx_valid=1.
- Burst: push 0x01..0x08 back-to-back -> tx_ready low after 8th; 8 start pulses in order; rx yields 0x01^0xFF.. (echo model) in order.
- RX backpressure: rx_ready=0, push 10 bytes -> start pulses stop after 8 captures; rx_ready=1 resumes, all 10 received, none lost.
- Timeout: busy never rises -> err_to=1 at start+BUSY_TO cycles; no RX push; next byte proceeds; err_clr clears err_to.
- Reset mid-transfer: assert rst during WAIT_DONE with 3 bytes queued -> next edge: FIFOs empty, spi_start=0, seq_busy=0, rx_valid=0.
- SPI_SEQ_GAP_EN build: two bytes -> start pulses separated by 3+GAP_CYCLES cycles after busy falls.
